// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture FIFO: drop counter width, occupancy
// width helper and the rotate-XOR signature step.
package capture_pkg;

   localparam int DROP_CNT_W = 8;
   // Widest data word the signature helper supports.
   localparam int SIG_MAX_W  = 64;

   typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

   // Occupancy must represent 0..DEPTH inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Rotate sig left by one within 'width' bits, then XOR in data.
   function automatic logic [SIG_MAX_W-1:0] sig_next(input logic [SIG_MAX_W-1:0] sig,
                                                     input logic [SIG_MAX_W-1:0] data,
                                                     input int                   width);
      logic [SIG_MAX_W-1:0] mask;
      logic [SIG_MAX_W-1:0] rot;
      mask = (width >= SIG_MAX_W) ? '1 : ((SIG_MAX_W'(1) << width) - SIG_MAX_W'(1));
      rot  = ((sig << 1) | (sig >> (width - 1))) & mask;
      return rot ^ (data & mask);
   endfunction

endpackage

// File: rtl/capture_fifo_core.sv
// First-word-fall-through storage with wrap-around pointers and occupancy count.
// The head reads zero whenever the FIFO is empty, including during reset.
module capture_fifo_core
   import capture_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear,
   input  logic                          push,
   input  logic                          pop,
   input  logic [WIDTH-1:0]              in_data,
   output logic [WIDTH-1:0]              out_data,
   output logic [cnt_width(DEPTH)-1:0]   count,
   output logic                          full,
   output logic                          empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign out_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/capture_fifo.sv
// Capture stage: the upstream cannot stall, so words arriving while full are
// dropped and counted; accepted words fold into a rotate-XOR signature.
module capture_fifo
   import capture_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear,
   input  logic                          in_valid,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          in_ready,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic [cnt_width(DEPTH)-1:0]   count,
   output logic [WIDTH-1:0]              signature,
   output logic [DROP_CNT_W-1:0]         drop_cnt
);

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic drop;

   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign pop  = out_valid && out_ready && !clear;
   assign push = in_valid && !clear && (!full || pop);
   assign drop = in_valid && !clear && full && !pop;

   capture_fifo_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .push     (push),
      .pop      (pop),
      .in_data  (in_data),
      .out_data (out_data),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   assign out_valid = !empty;
   assign in_ready  = !full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         signature <= '0;
         drop_cnt  <= '0;
      end else if (clear) begin
         signature <= '0;
         drop_cnt  <= '0;
      end else begin
         if (push)
            signature <= WIDTH'(sig_next(SIG_MAX_W'(signature), SIG_MAX_W'(in_data), WIDTH));
         if (drop && (drop_cnt != '1))
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_capture_fifo.sv
// Directed bench for capture_fifo with WIDTH=32, DEPTH=4 and hand-computed
// expectations for signature, occupancy, drop count and head ordering.
module tb_capture_fifo;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  count;
   logic [31:0] signature;
   logic [7:0]  drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   capture_fifo #(.WIDTH(32), .DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .signature (signature),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs at the falling edge, let one rising edge pass, settle 1 time unit.
   task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic c);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      clear     = c;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      clear     = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #12;
      n_checks++; if (count !== 3'd0)      begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
      n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_checks++; if (signature !== 32'd0) begin n_fail++; $display("FAIL reset_signature got %h want 0", signature); end
      n_checks++; if (drop_cnt !== 8'd0)   begin n_fail++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
      n_checks++; if (out_data !== 32'd0)  begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_push_three();
      cycle(1'b1, 32'h1, 1'b0, 1'b0);
      n_checks++; if (signature !== 32'h1) begin n_fail++; $display("FAIL sig_after_1 got %h want 1", signature); end
      n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h1) begin n_fail++; $display("FAIL latency_head got v=%b d=%h want v=1 d=1", out_valid, out_data); end
      cycle(1'b1, 32'h2, 1'b0, 1'b0);
      n_checks++; if (signature !== 32'h0) begin n_fail++; $display("FAIL sig_after_2 got %h want 0", signature); end
      cycle(1'b1, 32'h3, 1'b0, 1'b0);
      n_checks++; if (count !== 3'd3)      begin n_fail++; $display("FAIL push3_count got %0d want 3", count); end
      n_checks++; if (out_data !== 32'h1)  begin n_fail++; $display("FAIL push3_head got %h want 1", out_data); end
      n_checks++; if (signature !== 32'h3) begin n_fail++; $display("FAIL push3_sig got %h want 3", signature); end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_pop [4];
      exp_pop[0] = 32'h2; exp_pop[1] = 32'h3; exp_pop[2] = 32'h4; exp_pop[3] = 32'hB;
      cycle(1'b1, 32'h4, 1'b0, 1'b0);
      n_checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_state got count=%0d in_ready=%b want 4/0", count, in_ready); end
      n_checks++; if (signature !== 32'h2) begin n_fail++; $display("FAIL sig_after_4 got %h want 2", signature); end
      cycle(1'b1, 32'hA, 1'b0, 1'b0);
      n_checks++; if (drop_cnt !== 8'd1)   begin n_fail++; $display("FAIL drop_one got %0d want 1", drop_cnt); end
      n_checks++; if (count !== 3'd4)      begin n_fail++; $display("FAIL drop_count got %0d want 4", count); end
      n_checks++; if (signature !== 32'h2) begin n_fail++; $display("FAIL drop_sig got %h want 2", signature); end
      n_checks++; if (out_data !== 32'h1)  begin n_fail++; $display("FAIL pop0 got %h want 1", out_data); end
      cycle(1'b1, 32'hB, 1'b1, 1'b0);
      n_checks++; if (count !== 3'd4)      begin n_fail++; $display("FAIL full_pushpop_count got %0d want 4", count); end
      n_checks++; if (drop_cnt !== 8'd1)   begin n_fail++; $display("FAIL full_pushpop_drop got %0d want 1", drop_cnt); end
      n_checks++; if (signature !== 32'hF) begin n_fail++; $display("FAIL sig_after_B got %h want f", signature); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp_pop[i]) begin
            n_fail++; $display("FAIL pop%0d got v=%b d=%h want v=1 d=%h", i + 1, out_valid, out_data, exp_pop[i]);
         end
         cycle(1'b0, 32'h0, 1'b1, 1'b0);
      end
      n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drained got count=%0d v=%b want 0/0", count, out_valid); end
      idle();
   endtask

   task automatic test_saturate();
      cycle(1'b1, 32'h10, 1'b0, 1'b0);
      cycle(1'b1, 32'h20, 1'b0, 1'b0);
      cycle(1'b1, 32'h30, 1'b0, 1'b0);
      cycle(1'b1, 32'h40, 1'b0, 1'b0);
      n_checks++; if (signature !== 32'hD0) begin n_fail++; $display("FAIL refill_sig got %h want d0", signature); end
      for (int i = 0; i < 100; i++) cycle(1'b1, 32'h55 + i, 1'b0, 1'b0);
      n_checks++; if (drop_cnt !== 8'd101) begin n_fail++; $display("FAIL drop_101 got %0d want 101", drop_cnt); end
      for (int i = 0; i < 200; i++) cycle(1'b1, 32'h99 + i, 1'b0, 1'b0);
      n_checks++; if (drop_cnt !== 8'hFF)  begin n_fail++; $display("FAIL drop_sat got %0d want 255", drop_cnt); end
      n_checks++; if (signature !== 32'hD0 || count !== 3'd4) begin n_fail++; $display("FAIL sat_state got sig=%h count=%0d want d0/4", signature, count); end
      idle();
   endtask

   task automatic test_clear();
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (count !== 3'd2 || out_data !== 32'h30) begin n_fail++; $display("FAIL pre_clear got count=%0d head=%h want 2/30", count, out_data); end
      cycle(1'b1, 32'h99, 1'b1, 1'b1);
      n_checks++; if (count !== 3'd0)      begin n_fail++; $display("FAIL clear_count got %0d want 0", count); end
      n_checks++; if (out_valid !== 1'b0 || out_data !== 32'd0) begin n_fail++; $display("FAIL clear_head got v=%b d=%h want 0/0", out_valid, out_data); end
      n_checks++; if (signature !== 32'd0) begin n_fail++; $display("FAIL clear_sig got %h want 0", signature); end
      n_checks++; if (drop_cnt !== 8'd0)   begin n_fail++; $display("FAIL clear_drop got %0d want 0", drop_cnt); end
      n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL clear_in_ready got %b want 1", in_ready); end
      idle();
   endtask

   task automatic test_async_reset();
      cycle(1'b1, 32'h1, 1'b0, 1'b0);
      cycle(1'b1, 32'h2, 1'b0, 1'b0);
      cycle(1'b1, 32'h3, 1'b0, 1'b0);
      n_checks++; if (count !== 3'd3)      begin n_fail++; $display("FAIL pre_reset_count got %0d want 3", count); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL async_count got count=%0d v=%b want 0/0", count, out_valid); end
      n_checks++; if (out_data !== 32'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL async_out got d=%h rdy=%b want 0/1", out_data, in_ready); end
      n_checks++; if (signature !== 32'd0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL async_sig got sig=%h drop=%0d want 0/0", signature, drop_cnt); end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 32'h5, 1'b0, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h5) begin n_fail++; $display("FAIL post_reset_head got v=%b d=%h want 1/5", out_valid, out_data); end
      n_checks++; if (signature !== 32'h5 || count !== 3'd1) begin n_fail++; $display("FAIL post_reset_sig got sig=%h count=%0d want 5/1", signature, count); end
      idle();
   endtask

   initial begin
      test_reset();
      test_push_three();
      test_overflow();
      test_saturate();
      test_clear();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/capture_fifo.md
# capture_fifo

Downstream capture stage for the per-bit transform block. It registers each WIDTH-bit result word into a small first-word-fall-through FIFO with a valid/ready output port. It keeps a running rotate-XOR signature of every accepted word and counts words dropped on overflow. The transform stage upstream cannot stall, so the capture stage tolerates backpressure by dropping words and reporting each drop.

## Interface
- WIDTH, 32: data word width; ≥ 2.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush; highest priority.
- in_valid  input  1  upstream word present.
- in_data  input  WIDTH  upstream word (transform output).
- in_ready  output  1  = !full; informational only, upstream ignores it.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head.
- out_data  output  WIDTH  FIFO head word.
- count  output  $clog2(DEPTH+1)  occupancy.
- signature  output  WIDTH  running signature of accepted words.
- drop_cnt  output  8  dropped words, saturates at 255.

## Operation
- pop = out_valid && out_ready.
- push = in_valid && !clear && (!full || pop). A push while full is accepted only when a pop happens in the same cycle.
- Drop: in_valid && !clear && full && !pop.
  - The word is discarded.
  - drop_cnt increments and saturates at 8'hFF.
  - signature is unchanged.
- Signature update on each push: sig ← {sig[WIDTH-2:0], sig[WIDTH-1]} ^ in_data.
- count ← count + push − pop. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- out_data is the head entry. It is valid whenever count ≠ 0 and holds its value while out_valid && !out_ready.
- clear has priority over push, pop and drop in the same cycle:
  - count, pointers, signature and drop_cnt go to 0.
  - No push, pop or drop is recorded. The in_valid word is discarded and not counted as a drop.
- rst_n low forces all of the following immediately, regardless of clk:
  - count, pointers, signature, drop_cnt, out_valid = 0.
  - in_ready = 1.
  - out_data = 0; storage contents are don't-care but out_data reads 0.
  - This holds when reset is asserted mid-stream, including in a cycle with push or pop active.

## Timing
- All state updates happen on the rising edge of clk. Outputs are registered or derived from registers only; there is no combinational path from in_* to out_*.
- Latency: a word pushed at edge N appears on out_data with out_valid=1 after edge N, i.e. in the following cycle.
- A push into an empty FIFO cannot be popped in the same cycle.
- Push and pop in the same cycle leave count unchanged. This applies both when full and when partially full.
- in_ready (!full) is updated from the registered count.
- On rst_n release, the first edge with rst_n=1 may push.

## Structure
- Package capture_pkg:
  - localparam DROP_CNT_W = 8.
  - function sig_next(sig, data) implementing the rotate-XOR.
  - typedef for the count width helper.
- Storage, pointers and count live in one sub-module, capture_fifo_core (parameterized WIDTH, DEPTH, FWFT head).
- The top level adds the drop logic, signature and clear priority.

## Test plan
All scenarios use WIDTH=32, DEPTH=4.
- Reset: rst_n=0 → count=0, out_valid=0, in_ready=1, signature=0, drop_cnt=0, out_data=0.
- Push 0x1, 0x2, 0x3 with out_ready=0 → count=3, out_data=0x1, signature=0x3 (intermediate values 0x1, then 0x0).
- Fill to 4 and push 0xA with out_ready=0 → in_ready=0, drop_cnt=1, count=4, signature unchanged. Then push 0xB with out_ready=1 → accepted, count stays 4, pops return 1, 2, 3, 4, 0xB in order.
- Push 300 words while full with out_ready=0 → drop_cnt saturates at 255, no wrap.
- clear together with in_valid=1 and out_ready=1 at count=2 → next cycle count=0, out_valid=0, signature=0, drop_cnt=0; the word is neither stored nor counted.
- Assert rst_n between edges with count=3 → outputs go to their reset values before the next edge; after release, a push of 0x5 gives out_data=0x5 and signature=0x5.
